// File: rtl/mmio_timer_if.sv
// Data-bus view of the timer: the CPU load/store signals shared with DataMemory.
// Signal names follow the bus they are taken from.
interface mmio_timer_if;
  logic        sel;
  logic        mem_write;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  wlen;
  logic [31:0] rdata;

  modport master (
    output sel,
    output mem_write,
    output addr,
    output wdata,
    output wlen,
    input  rdata
  );

  modport slave (
    input  sel,
    input  mem_write,
    input  addr,
    input  wdata,
    input  wlen,
    output rdata
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped timer: counter with compare match, optional auto-reload and level interrupt.
// Define TIMER_PRESCALE_EN to add the PRESC register and tick prescaler.
module mmio_timer #(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  mmio_timer_if.slave bus,
  output logic        irq
);

  localparam logic [2:0] IdxCtrl    = 3'd0;
  localparam logic [2:0] IdxCount   = 3'd1;
  localparam logic [2:0] IdxCompare = 3'd2;
  localparam logic [2:0] IdxStatus  = 3'd3;
  localparam logic [2:0] IdxPresc   = 3'd4;

  localparam logic [2:0] LenByte = 3'b001;
  localparam logic [2:0] LenHalf = 3'b010;
  localparam logic [2:0] LenWord = 3'b100;

  // Byte lanes touched by a store; misaligned halves and unknown lengths touch none.
  function automatic logic [3:0] laneEnables(input logic [2:0] len, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (len)
      LenByte: be = 4'b0001 << lane;
      LenHalf: if (!lane[0]) be = lane[1] ? 4'b1100 : 4'b0011;
      LenWord: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] alignData(input logic [2:0] len, input logic [31:0] data);
    logic [31:0] aligned;
    case (len)
      LenByte: aligned = {4{data[7:0]}};
      LenHalf: aligned = {2{data[15:0]}};
      default: aligned = data;
    endcase
    return aligned;
  endfunction

  function automatic logic [31:0] mergeLanes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
    end
    return merged;
  endfunction

  logic [2:0]  regIdx;
  logic [3:0]  wrBe;
  logic [31:0] wrData;
  logic        wrAny;
  logic        wrCtrl;
  logic        wrCount;
  logic        wrCompare;
  logic        wrStatus;

  assign regIdx    = bus.addr[4:2];
  assign wrBe      = (bus.sel && bus.mem_write) ? laneEnables(bus.wlen, bus.addr[1:0]) : 4'b0000;
  assign wrData    = alignData(bus.wlen, bus.wdata);
  assign wrAny     = |wrBe;
  assign wrCtrl    = wrAny && (regIdx == IdxCtrl);
  assign wrCount   = wrAny && (regIdx == IdxCount);
  assign wrCompare = wrAny && (regIdx == IdxCompare);
  assign wrStatus  = wrAny && (regIdx == IdxStatus);

  logic                 ctrlEn;
  logic                 ctrlAutoReload;
  logic                 ctrlIrqEn;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] compare;
  logic                 match;

  logic [31:0] ctrlWord;
  logic [31:0] countWord;
  logic [31:0] compareWord;
  logic [31:0] statusWord;
  logic [31:0] prescWord;
  logic [2:0]  ctrlNew;
  logic        matchClear;
  logic        hit;
  logic        tick;

  assign ctrlWord    = {29'd0, ctrlIrqEn, ctrlAutoReload, ctrlEn};
  assign countWord   = 32'(count);
  assign compareWord = 32'(compare);
  assign statusWord  = {31'd0, match};
  assign ctrlNew     = 3'(mergeLanes(ctrlWord, wrData, wrBe));
  // W1C: only a written 1 in bit 0 clears, untouched lanes never do.
  assign matchClear  = wrStatus && wrBe[0] && wrData[0];
  assign hit         = (count == compare);

`ifdef TIMER_PRESCALE_EN
  logic                   wrPresc;
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] pc;

  assign wrPresc = wrAny && (regIdx == IdxPresc);
  assign tick    = ctrlEn && (pc == presc);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      pc    <= '0;
    end else begin
      if (wrPresc) begin
        presc <= PRESC_WIDTH'(mergeLanes(prescWord, wrData, wrBe));
        pc    <= '0;
      end else if (!ctrlEn || tick) begin
        pc <= '0;
      end else begin
        pc <= pc + PRESC_WIDTH'(1);
      end
    end
  end
`else
  logic [PRESC_WIDTH-1:0] presc;

  assign presc = '0;
  assign tick  = ctrlEn;
`endif

  assign prescWord = 32'(presc);

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrlEn         <= 1'b0;
      ctrlAutoReload <= 1'b0;
      ctrlIrqEn      <= 1'b0;
      count          <= '0;
      compare        <= '1;
      match          <= 1'b0;
    end else begin
      if (wrCtrl) begin
        {ctrlIrqEn, ctrlAutoReload, ctrlEn} <= ctrlNew;
      end
      if (wrCompare) begin
        compare <= CNT_WIDTH'(mergeLanes(compareWord, wrData, wrBe));
      end
      // A CPU store to COUNT takes priority over the tick in the same cycle.
      if (wrCount) begin
        count <= CNT_WIDTH'(mergeLanes(countWord, wrData, wrBe));
      end else if (tick) begin
        count <= (hit && ctrlAutoReload) ? '0 : count + CNT_WIDTH'(1);
      end
      if (tick && hit) begin
        match <= 1'b1;
      end else if (matchClear) begin
        match <= 1'b0;
      end
    end
  end

  logic [31:0] rdSel;

  always_comb begin
    rdSel = 32'd0;
    case (regIdx)
      IdxCtrl:    rdSel = ctrlWord;
      IdxCount:   rdSel = countWord;
      IdxCompare: rdSel = compareWord;
      IdxStatus:  rdSel = statusWord;
      IdxPresc:   rdSel = prescWord;
      default:    rdSel = 32'd0;
    endcase
  end

  assign bus.rdata = (bus.sel && !bus.mem_write) ? rdSel : 32'd0;
  assign irq       = match & ctrlIrqEn;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus random bus traffic against a register-level model.
module tb_mmio_timer;
  logic clock = 1'b0;
  logic reset;
  logic irq;

  mmio_timer_if bus();

  mmio_timer #(.CNT_WIDTH(32), .PRESC_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .irq  (irq)
  );

  always #5 clock = ~clock;

`ifdef TIMER_PRESCALE_EN
  localparam bit PrescEn = 1'b1;
`else
  localparam bit PrescEn = 1'b0;
`endif

  localparam logic [2:0] B = 3'b001;
  localparam logic [2:0] H = 3'b010;
  localparam logic [2:0] W = 3'b100;

  int tests = 0;
  int fails = 0;
  logic [31:0] resetExp [5];

  // Reference state: the five architectural registers plus the prescale position.
  logic [2:0]  mCtrl;
  logic [31:0] mCount;
  logic [31:0] mCompare;
  logic        mMatch;
  logic [7:0]  mPresc;
  int unsigned mPc;

  task automatic modelReset();
    mCtrl = 3'd0; mCount = 32'd0; mCompare = 32'hFFFF_FFFF;
    mMatch = 1'b0; mPresc = 8'd0; mPc = 0;
  endtask

  function automatic bit storeHits(input logic [4:0] a, input logic [2:0] len);
    return (len == B) || (len == W) || (len == H && !a[0]);
  endfunction

  function automatic logic [31:0] storeResult(input logic [31:0] old, input logic [4:0] a,
                                              input logic [31:0] d, input logic [2:0] len);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (len == B) b[a[1:0]] = d[7:0];
    else if (len == H && !a[0]) begin
      b[{a[1], 1'b0}] = d[7:0];
      b[{a[1], 1'b1}] = d[15:8];
    end else if (len == W) begin
      for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] idx);
    case (idx)
      3'd0: return {29'd0, mCtrl};
      3'd1: return mCount;
      3'd2: return mCompare;
      3'd3: return {31'd0, mMatch};
      3'd4: return PrescEn ? {24'd0, mPresc} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input logic s, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic [2:0] len);
    bit tk, hitNow;
    logic [31:0] nCount, v;
    logic nMatch;
    int unsigned nPc;
    tk     = mCtrl[0] && (!PrescEn || mPc == mPresc);
    hitNow = tk && (mCount == mCompare);
    nCount = mCount;
    if (tk) nCount = (hitNow && mCtrl[1]) ? 32'd0 : mCount + 32'd1;
    nPc    = (!mCtrl[0] || tk) ? 0 : mPc + 1;
    nMatch = mMatch;
    if (s && we && storeHits(a, len)) begin
      case (a[4:2])
        3'd0: begin v = storeResult({29'd0, mCtrl}, a, d, len); mCtrl = v[2:0]; end
        3'd1: nCount = storeResult(mCount, a, d, len);
        3'd2: mCompare = storeResult(mCompare, a, d, len);
        3'd3: begin v = storeResult(32'd0, a, d, len); if (v[0]) nMatch = 1'b0; end
        3'd4: if (PrescEn) begin
          v = storeResult({24'd0, mPresc}, a, d, len);
          mPresc = v[7:0];
          nPc = 0;
        end
        default: ;
      endcase
    end
    if (hitNow) nMatch = 1'b1;
    mCount = nCount; mMatch = nMatch; mPc = nPc;
  endtask

  // One bus cycle: drive, sample at negedge against the model, then advance the model.
  task automatic doCycle(input logic s, input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [2:0] len, output logic [31:0] rd, output logic iv);
    logic [31:0] expRd;
    logic expIrq;
    bus.sel = s; bus.mem_write = we; bus.addr = a; bus.wdata = d; bus.wlen = len;
    @(negedge clock);
    rd = bus.rdata;
    iv = irq;
    expRd  = (s && !we) ? modelRead(a[4:2]) : 32'd0;
    expIrq = mMatch & mCtrl[2];
    tests++;
    if (rd !== expRd) begin
      fails++;
      $display("FAIL model_rdata sel=%b we=%b addr=%h got=%h exp=%h", s, we, a, rd, expRd);
    end
    tests++;
    if (iv !== expIrq) begin
      fails++;
      $display("FAIL model_irq got=%b exp=%b", iv, expIrq);
    end
    @(posedge clock);
    if (reset) modelReset();
    else modelStep(s, we, a, d, len);
    #1;
  endtask

  task automatic store(input logic [4:0] a, input logic [31:0] d, input logic [2:0] len);
    logic [31:0] rd;
    logic iv;
    doCycle(1'b1, 1'b1, a, d, len, rd, iv);
  endtask

  task automatic load(input logic [4:0] a, output logic [31:0] rd, output logic iv);
    doCycle(1'b1, 1'b0, a, 32'd0, W, rd, iv);
  endtask

  task automatic doReset();
    reset = 1'b1;
    store(5'h04, 32'h1234_5678, W);
    reset = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic iv;
    doReset();
    for (int i = 0; i < 5; i++) begin
      load(5'(i * 4), rd, iv);
      checkVal("reset_reg", rd, resetExp[i]);
      checkVal("reset_irq", {31'd0, iv}, 32'd0);
    end
  endtask

  task automatic test_match();
    logic [31:0] rd;
    logic iv;
    doReset();
    store(5'h08, 32'd5, W);
    store(5'h00, 32'h7, W);
    for (int j = 0; j < 6; j++) begin
      load(5'h04, rd, iv);
      checkVal("match_count", rd, 32'(j));
      checkVal("match_irq_low", {31'd0, iv}, 32'd0);
    end
    load(5'h04, rd, iv);
    checkVal("match_reload", rd, 32'd0);
    checkVal("match_irq_high", {31'd0, iv}, 32'd1);
    load(5'h0C, rd, iv);
    checkVal("match_status", rd, 32'd1);
    store(5'h0C, 32'd1, W);
    load(5'h0C, rd, iv);
    checkVal("match_w1c", rd, 32'd0);
    checkVal("match_irq_clr", {31'd0, iv}, 32'd0);
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    logic iv;
    doReset();
    store(5'h04, 32'h1122_3344, W);
    store(5'h05, 32'h0000_00AA, B);
    store(5'h06, 32'h0000_BEEF, H);
    load(5'h04, rd, iv);
    checkVal("lanes_merge", rd, 32'hBEEF_AA44);
    store(5'h05, 32'h0000_1234, H);
    load(5'h04, rd, iv);
    checkVal("lanes_misaligned", rd, 32'hBEEF_AA44);
    store(5'h04, 32'h0, 3'b011);
    load(5'h04, rd, iv);
    checkVal("lanes_badlen", rd, 32'hBEEF_AA44);
    store(5'h14, 32'hFFFF_FFFF, W);
    load(5'h14, rd, iv);
    checkVal("unmapped", rd, 32'd0);
    store(5'h01, 32'h0000_00FF, B);
    load(5'h00, rd, iv);
    checkVal("ctrl_upper", rd, 32'd0);
  endtask

  task automatic test_presc();
    logic [31:0] rd;
    logic iv;
    doReset();
    store(5'h10, 32'd3, W);
    load(5'h10, rd, iv);
    checkVal("presc_read", rd, PrescEn ? 32'd3 : 32'd0);
    store(5'h00, 32'd1, W);
    for (int i = 0; i < 12; i++) begin
      load(5'h04, rd, iv);
      checkVal("presc_count", rd, PrescEn ? 32'(i / 4) : 32'(i));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic iv;
    doReset();
    store(5'h00, 32'd1, W);
    store(5'h04, 32'd100, W);
    load(5'h04, rd, iv);
    checkVal("store_beats_tick", rd, 32'd100);
    load(5'h04, rd, iv);
    checkVal("tick_after_store", rd, 32'd101);
    store(5'h00, 32'd0, W);
    load(5'h04, rd, iv);
    checkVal("en_clear_last_tick", rd, 32'd103);
    load(5'h04, rd, iv);
    checkVal("en_clear_frozen", rd, 32'd103);
    doReset();
    store(5'h08, 32'd3, W);
    store(5'h00, 32'd3, W);
    for (int j = 0; j < 7; j++) begin
      load(5'h04, rd, iv);
      checkVal("reload_count", rd, 32'(j % 4));
    end
    store(5'h0C, 32'd1, W);
    load(5'h0C, rd, iv);
    checkVal("match_beats_w1c", rd, 32'd1);
    store(5'h0C, 32'd1, W);
    load(5'h0C, rd, iv);
    checkVal("w1c_plain", rd, 32'd0);
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic iv;
    doReset();
    store(5'h08, 32'd3, W);
    store(5'h04, 32'hFFFF_FFFE, W);
    store(5'h00, 32'd5, W);
    for (int j = 0; j < 6; j++) begin
      load(5'h04, rd, iv);
      checkVal("wrap_count", rd, 32'hFFFF_FFFE + 32'(j));
      checkVal("wrap_no_irq", {31'd0, iv}, 32'd0);
    end
    load(5'h0C, rd, iv);
    checkVal("wrap_match", rd, 32'd1);
    checkVal("wrap_irq", {31'd0, iv}, 32'd1);
    doReset();
    for (int i = 0; i < 5; i++) begin
      load(5'(i * 4), rd, iv);
      checkVal("midcount_reset", rd, resetExp[i]);
    end
    checkVal("midcount_irq", {31'd0, iv}, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] rd, d;
    logic iv, s, we;
    logic [2:0] lens [8];
    logic [4:0] a;
    lens = '{B, H, W, B, H, W, 3'b011, 3'b000};
    doReset();
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 2) == 0);
      a  = 5'($urandom_range(0, 31));
      d  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
      doCycle(s, we, a, d, lens[$urandom_range(0, 7)], rd, iv);
    end
    reset = 1'b0;
  endtask

  initial begin
    resetExp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    reset = 1'b1;
    bus.sel = 1'b0; bus.mem_write = 1'b0; bus.addr = 5'd0; bus.wdata = 32'd0; bus.wlen = 3'd0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_match();
    test_lanes();
    test_presc();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
